// File: rtl/audio_stream_sequencer.sv
// Audio CODEC FIFO sequencer: pops a stereo sample, applies mute/attenuation,
// pushes it back to the DAC FIFO and strobes the raw capture downstream.
module audio_stream_sequencer #(
   parameter int DATA_W  = 24,
   parameter int TIMEOUT = 1024,
   parameter int DROP_W  = 16
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              enable,
   input  logic              mute,
   input  logic [2:0]        gain_shift,
   input  logic              read_ready,
   input  logic [DATA_W-1:0] readdata_left,
   input  logic [DATA_W-1:0] readdata_right,
   input  logic              write_ready,
   output logic              read,
   output logic              write,
   output logic [DATA_W-1:0] writedata_left,
   output logic [DATA_W-1:0] writedata_right,
   output logic              sample_valid,
   output logic [DATA_W-1:0] sample_left,
   output logic [DATA_W-1:0] sample_right,
   output logic [DROP_W-1:0] drop_count,
   output logic              busy
);

   localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      POP,
      WAIT_WR,
      PUSH
   } state_t;

   state_t              state_q, state_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic                read_q, read_d;
   logic                write_q, write_d;
   logic                sample_valid_q, sample_valid_d;
   logic [DATA_W-1:0]   sample_left_q, sample_left_d;
   logic [DATA_W-1:0]   sample_right_q, sample_right_d;
   logic [DATA_W-1:0]   writedata_left_q, writedata_left_d;
   logic [DATA_W-1:0]   writedata_right_q, writedata_right_d;
   logic [DROP_W-1:0]   drop_q, drop_d;

   // Shift in a signed context of its own so the mute mux cannot turn it logical.
   logic signed [DATA_W-1:0] shifted_left;
   logic signed [DATA_W-1:0] shifted_right;

   assign shifted_left  = $signed(sample_left_q) >>> gain_shift;
   assign shifted_right = $signed(sample_right_q) >>> gain_shift;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
      state_d           = state_q;
      timer_d           = timer_q;
      read_d            = 1'b0;
      write_d           = 1'b0;
      sample_valid_d    = 1'b0;
      sample_left_d     = sample_left_q;
      sample_right_d    = sample_right_q;
      writedata_left_d  = writedata_left_q;
      writedata_right_d = writedata_right_q;
      drop_d            = drop_q;

      case (state_q)
         IDLE: begin
            if (enable && read_ready) begin
               sample_left_d  = readdata_left;
               sample_right_d = readdata_right;
               read_d         = 1'b1;
               sample_valid_d = 1'b1;
               state_d        = POP;
            end
         end
         POP: begin
            writedata_left_d  = mute ? '0 : shifted_left;
            writedata_right_d = mute ? '0 : shifted_right;
            timer_d           = '0;
            state_d           = WAIT_WR;
         end
         WAIT_WR: begin
            // A ready DAC FIFO wins over an expiring timer in the same cycle.
            if (write_ready) begin
               write_d = 1'b1;
               state_d = PUSH;
            end else if (timer_q == TIMER_LAST) begin
               if (drop_q != '1) begin
                  drop_d = drop_q + 1'b1;
               end
               state_d = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         PUSH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q           <= IDLE;
         timer_q           <= '0;
         read_q            <= 1'b0;
         write_q           <= 1'b0;
         sample_valid_q    <= 1'b0;
         sample_left_q     <= '0;
         sample_right_q    <= '0;
         writedata_left_q  <= '0;
         writedata_right_q <= '0;
         drop_q            <= '0;
      end else begin
         state_q           <= state_d;
         timer_q           <= timer_d;
         read_q            <= read_d;
         write_q           <= write_d;
         sample_valid_q    <= sample_valid_d;
         sample_left_q     <= sample_left_d;
         sample_right_q    <= sample_right_d;
         writedata_left_q  <= writedata_left_d;
         writedata_right_q <= writedata_right_d;
         drop_q            <= drop_d;
      end
   end

   assign read            = read_q;
   assign write           = write_q;
   assign sample_valid    = sample_valid_q;
   assign sample_left     = sample_left_q;
   assign sample_right    = sample_right_q;
   assign writedata_left  = writedata_left_q;
   assign writedata_right = writedata_right_q;
   assign drop_count      = drop_q;
   assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_audio_stream_sequencer.sv
// Directed bench for audio_stream_sequencer: passthrough, attenuation, mute,
// timeout/saturation, enable gating, write-vs-timeout priority, mid-op reset.
module tb_audio_stream_sequencer;

   localparam int DATA_W  = 24;
   localparam int TIMEOUT = 8;
   localparam int DROP_W  = 2;

   logic              clk;
   logic              reset;
   logic              enable;
   logic              mute;
   logic [2:0]        gain_shift;
   logic              read_ready;
   logic [DATA_W-1:0] readdata_left;
   logic [DATA_W-1:0] readdata_right;
   logic              write_ready;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata_left;
   logic [DATA_W-1:0] writedata_right;
   logic              sample_valid;
   logic [DATA_W-1:0] sample_left;
   logic [DATA_W-1:0] sample_right;
   logic [DROP_W-1:0] drop_count;
   logic              busy;

   int total = 0;
   int bad   = 0;

   audio_stream_sequencer #(
      .DATA_W (DATA_W),
      .TIMEOUT(TIMEOUT),
      .DROP_W (DROP_W)
   ) dut (
      .CLOCK_50       (clk),
      .reset          (reset),
      .enable         (enable),
      .mute           (mute),
      .gain_shift     (gain_shift),
      .read_ready     (read_ready),
      .readdata_left  (readdata_left),
      .readdata_right (readdata_right),
      .write_ready    (write_ready),
      .read           (read),
      .write          (write),
      .writedata_left (writedata_left),
      .writedata_right(writedata_right),
      .sample_valid   (sample_valid),
      .sample_left    (sample_left),
      .sample_right   (sample_right),
      .drop_count     (drop_count),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full transaction with write_ready held high; checks strobe timing and data.
   task automatic run_sample(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                             input logic [2:0] sh, input logic mu,
                             input logic [DATA_W-1:0] exp_l, input logic [DATA_W-1:0] exp_r);
      readdata_left  = l;
      readdata_right = r;
      gain_shift     = sh;
      mute           = mu;
      enable         = 1'b1;
      write_ready    = 1'b1;
      read_ready     = 1'b1;
      step();
      read_ready = 1'b0;
      check("cap_read", read, 1);
      check("cap_valid", sample_valid, 1);
      check("cap_sl", sample_left, l);
      check("cap_sr", sample_right, r);
      check("cap_write", write, 0);
      step();
      check("pop_read", read, 0);
      check("pop_valid", sample_valid, 0);
      check("pop_wl", writedata_left, exp_l);
      check("pop_wr", writedata_right, exp_r);
      step();
      check("push_write", write, 1);
      check("push_read", read, 0);
      step();
      check("done_write", write, 0);
      check("done_busy", busy, 0);
      check("done_sl", sample_left, l);
      check("done_wl", writedata_left, exp_l);
      enable = 1'b0;
   endtask

   // Transaction with write_ready low; optionally raises write_ready exactly on the timeout edge.
   task automatic run_timeout(input logic late_ready, input logic [DROP_W-1:0] exp_drop);
      logic ok;
      readdata_left  = 24'h000100;
      readdata_right = 24'h000200;
      gain_shift     = 3'd0;
      mute           = 1'b0;
      enable         = 1'b1;
      write_ready    = 1'b0;
      read_ready     = 1'b1;
      step();
      read_ready = 1'b0;
      enable     = 1'b0;
      step();
      ok = 1'b1;
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         if (!busy || write) ok = 1'b0;
         step();
      end
      check("to_wait", {31'd0, ok}, 1);
      if (late_ready) begin
         write_ready = 1'b1;
         step();
         write_ready = 1'b0;
         check("prio_write", write, 1);
         check("prio_drop", drop_count, exp_drop);
         step();
         check("prio_idle", busy, 0);
      end else begin
         step();
         check("to_idle", busy, 0);
         check("to_nowrite", write, 0);
         check("to_drop", drop_count, exp_drop);
      end
   endtask

   initial begin
      reset          = 1'b1;
      enable         = 1'b0;
      mute           = 1'b0;
      gain_shift     = 3'd0;
      read_ready     = 1'b0;
      readdata_left  = '0;
      readdata_right = '0;
      write_ready    = 1'b0;
      step();
      step();
      check("rst_busy", busy, 0);
      check("rst_read", read, 0);
      check("rst_write", write, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_drop", drop_count, 0);
      check("rst_wl", writedata_left, 0);
      check("rst_sl", sample_left, 0);
      reset = 1'b0;
      step();

      // Passthrough, attenuation, mute, shift-7 boundary
      run_sample(24'h123456, 24'hFEDCBA, 3'd0, 1'b0, 24'h123456, 24'hFEDCBA);
      run_sample(24'h800000, 24'h0007F0, 3'd4, 1'b0, 24'hF80000, 24'h00007F);
      run_sample(24'h7FFFFF, 24'h7FFFFF, 3'd0, 1'b1, 24'h000000, 24'h000000);
      run_sample(24'hFFFFFF, 24'h7FFFFF, 3'd7, 1'b0, 24'hFFFFFF, 24'h00FFFF);

      // Enable gating
      enable     = 1'b0;
      read_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("gate_read", read, 0);
         check("gate_busy", busy, 0);
      end
      read_ready = 1'b0;

      // Timeouts, priority on timeout edge, saturation of 2-bit counter
      run_timeout(1'b0, 2'd1);
      run_timeout(1'b0, 2'd2);
      run_timeout(1'b1, 2'd2);
      run_timeout(1'b0, 2'd3);
      run_timeout(1'b0, 2'd3);
      run_timeout(1'b0, 2'd3);

      // Reset while in WAIT_WR
      readdata_left  = 24'h0ABCDE;
      readdata_right = 24'h012345;
      enable         = 1'b1;
      write_ready    = 1'b0;
      read_ready     = 1'b1;
      step();
      read_ready = 1'b0;
      enable     = 1'b0;
      step();
      step();
      check("pre_rst_busy", busy, 1);
      check("pre_rst_wl", writedata_left, 24'h0ABCDE);
      reset = 1'b1;
      step();
      reset       = 1'b0;
      write_ready = 1'b1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_drop", drop_count, 0);
      check("mid_rst_wl", writedata_left, 0);
      check("mid_rst_wr", writedata_right, 0);
      check("mid_rst_write", write, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_rst_write", write, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/audio_stream_sequencer.md
Name: audio_stream_sequencer

Overview:
Sequences the audio CODEC FIFO handshake: pops one stereo sample when the CODEC has input data, applies mute/attenuation, and pushes the result back to the CODEC DAC FIFO. It also presents each captured sample to downstream analysis logic through a one-cycle strobe. Sits between audio_codec and the signal analysis path, and owns the codec read/write strobes.

Parameters:
DATA_W, 24, sample width per channel (signed two's complement)
TIMEOUT, 1024, CLOCK_50 cycles to wait for write_ready before dropping the sample (>=2)
DROP_W, 16, width of the dropped-sample counter

Ports:
CLOCK_50  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  permits starting a new sample transaction
mute  input  1  forces output samples to zero
gain_shift  input  3  attenuation: arithmetic right shift amount 0..7
read_ready  input  1  CODEC ADC FIFO holds a sample; readdata valid while high
readdata_left  input  DATA_W  CODEC left input sample
readdata_right  input  DATA_W  CODEC right input sample
write_ready  input  1  CODEC DAC FIFO can accept a sample
read  output  1  one-cycle pop strobe to CODEC
write  output  1  one-cycle push strobe to CODEC
writedata_left  output  DATA_W  processed left sample to CODEC
writedata_right  output  DATA_W  processed right sample to CODEC
sample_valid  output  1  one-cycle strobe: sample_left/right updated
sample_left  output  DATA_W  raw captured left sample (unprocessed)
sample_right  output  DATA_W  raw captured right sample
drop_count  output  DROP_W  samples discarded on write timeout, saturating
busy  output  1  high whenever state != IDLE

Behaviour:
- All outputs are registered except busy. On reset (sync, edge-sampled): state=IDLE; read, write, sample_valid=0; writedata_*, sample_*=0; drop_count=0; timer=0; busy=0.
- States: IDLE, POP, WAIT_WR, PUSH.
- IDLE: at the edge where enable && read_ready: capture readdata_left/right into sample_left/right; set read<=1; set sample_valid<=1; go to POP. Otherwise hold all outputs; read/write/sample_valid remain 0.
- POP (read and sample_valid high for exactly this cycle): read<=0; sample_valid<=0; writedata_* <= mute ? 0 : (captured >>> gain_shift), signed arithmetic shift, full DATA_W, no rounding; timer<=0; go to WAIT_WR.
- WAIT_WR: if write_ready, then write<=1 and go to PUSH. Else if timer==TIMEOUT-1, then drop_count<=drop_count+1 (saturating at all-ones) and go to IDLE with no write. Else timer<=timer+1. write_ready takes priority over timeout in the same cycle.
- PUSH (write high for exactly this cycle): write<=0; go to IDLE. writedata_* are held stable from POP until the next POP.
- Latency: read_ready sampled at edge k gives read high k..k+1, writedata valid at k+2, and, with write_ready high, write high k+2..k+3. Minimum sample period is 4 cycles; a new capture can occur at the PUSH->IDLE+1 edge.
- read and write are never high in the same cycle. read is never asserted unless read_ready was high at the asserting edge.
- enable gates only the IDLE exit. Deasserting enable mid-transaction lets the current sample complete or time out.
- mute and gain_shift are sampled only in POP. Changes elsewhere affect the next sample.
- gain_shift=0 with mute=0 gives bit-exact passthrough. Negative samples shifted by 7 saturate toward -1 (e.g. 0xFFFFFF stays 0xFFFFFF).
- Reset asserted in any state aborts the transaction at that edge: any pending read/write strobe is dropped next cycle, and drop_count clears.
- busy = (state != IDLE), combinational.

Test Plan:
- Passthrough: enable=1, gain_shift=0, mute=0, read_ready pulse with L=0x123456, R=0xFEDCBA, write_ready=1 -> read 1 cycle, sample_valid 1 cycle with the same values, write exactly 2 cycles after read with writedata L=0x123456, R=0xFEDCBA.
- Attenuation: gain_shift=4, L=0x800000, R=0x0007F0 -> writedata L=0xF80000, R=0x00007F; sample_left/right stay raw.
- Mute: mute=1, L=0x7FFFFF -> write strobe still issued, writedata_left=writedata_right=0, sample_left=0x7FFFFF.
- Timeout: TIMEOUT=8, write_ready held 0 -> no write, returns to IDLE 8 cycles after POP, drop_count=1; repeat 3 times -> 3. With DROP_W=2 and 5 drops -> saturates at 3.
- Gating and priority: enable=0 with read_ready=1 -> read never asserts. write_ready rising on the exact timeout cycle -> write issued, drop_count unchanged.
- Reset mid-op: assert reset in WAIT_WR -> next cycle state IDLE, busy=0, write never asserts, drop_count=0, writedata_*=0.
